icache_fetch_responder: RTL
===========================

Name: icache_fetch_responder

Overview:
Responder end of the fetch request handshake (inst_req / inst_index_ok) used by the IF pipeline's first cache-trace stage.
- Models the instruction cache's two pipeline stages:
  - Stage 1 accepts an index (asserts inst_index_ok).
  - Stage 2 holds the request, does tag compare and returns a 4-word line with inst_data_ok.
- On a miss, a small FSM issues a line refill burst to the memory-side read port.
- Direct-mapped cache with 16-byte lines.

Parameters:
INDEX_W, 6, set-index width (2^INDEX_W lines); index = vaddr[INDEX_W+3:4].
TAG_W, 25-INDEX_W, tag width; tag = vaddr[28:INDEX_W+4] (kseg physical mapping, paddr = {3'b000, vaddr[28:0]}).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-low reset.
inst_req  in  1  fetch request valid.
inst_vaddr  in  32  fetch virtual address; bits [3:0] ignored for lookup.
inst_cancel  in  1  branch-fix or exception cancel; kills the request in stage 2.
inst_stage2_allowin  in  1  downstream stage accepts returned data this cycle.
inst_index_ok  out  1  request accepted into stage 2 this cycle (combinational).
inst_data_ok  out  1  stage-2 line data valid (combinational).
inst_rdata  out  128  line data, word0 = bits [31:0].
rd_req  out  1  refill burst request (registered).
rd_addr  out  32  refill line address, 16-byte aligned.
rd_rdy  in  1  memory accepts rd_req.
ret_valid  in  1  refill return word valid.
ret_last  in  1  last word of the burst.
ret_data  in  32  refill return word.

Behaviour:
Reset (rst=0, async):
- All line valid bits = 0; s2_valid = 0; s2_canceled = 0; state = LOOKUP.
- rd_req = 0; rd_addr = 0; refill word counter = 0.
- Combinational outputs are 0 while in reset.

Stage 2 holds s2_valid, s2_vaddr and s2_canceled.
- hit = s2_valid && valid[idx] && tag[idx] == s2 tag.

State LOOKUP:
- inst_index_ok = inst_req && (!s2_valid || s2_leave).
- s2_leave = s2_canceled || inst_cancel || (hit && inst_stage2_allowin).
- On inst_index_ok: s2_valid <= 1, s2_vaddr <= inst_vaddr, s2_canceled <= inst_cancel.
- Else if s2_leave: s2_valid <= 0.
- inst_data_ok = hit && !s2_canceled && !inst_cancel; inst_rdata = data[idx], otherwise 0.
- Data and inst_data_ok are held stable while inst_stage2_allowin = 0.
- inst_cancel while s2 is held (not leaving) sets s2_canceled <= 1.
- s2_valid && !hit && !s2_canceled && !inst_cancel: latch rd_addr = {paddr[31:4], 4'b0}, set rd_req <= 1, go to MISS.

State MISS:
- inst_index_ok = 0 and inst_data_ok = 0.
- rd_req is held high until rd_rdy = 1; in that cycle rd_req <= 0, counter <= 0, go to REFILL.

State REFILL:
- inst_index_ok = 0 and inst_data_ok = 0.
- Each ret_valid writes ret_data into buffer word [counter]; counter increments, wrapping 3 -> 0.
- On ret_valid && ret_last: write buffer (with the current word merged) into data[idx]; set tag[idx] and valid[idx] = 1; go to LOOKUP.
- The next cycle hits, so miss-to-data_ok latency is the refill time plus 1 cycle.

Cancel interactions:
- inst_cancel during MISS or REFILL sets s2_canceled.
- The refill still completes and the line is installed.
- Back in LOOKUP, the canceled stage-2 entry is dropped with no inst_data_ok.

Boundary conditions:
- ret_last with counter != 3: line installed as counted; words not yet received keep stale buffer contents.
- Simultaneous index_ok and a leaving hit (allowin = 1): back-to-back hits at 1 request per cycle.
- New inst_req is never accepted while a miss is outstanding.

Test Plan:
1. Reset, then inst_req at 0x8000_0010 -> index_ok=1; next cycle miss; rd_req=1 with rd_addr=0x0000_0010 until rd_rdy. Return 4 words 0x11,0x22,0x33,0x44 with last on the 4th -> one cycle later data_ok=1, inst_rdata=0x00000044_00000033_00000022_00000011.
2. After scenario 1, inst_req held with addresses 0x8000_0010, 0x8000_0014, 0x8000_0018 and allowin=1 -> index_ok every cycle; data_ok on three consecutive cycles with the same line.
3. Hit with allowin=0 for 3 cycles -> data_ok and inst_rdata stable; index_ok=0 for a new inst_req until allowin=1, then index_ok=1 in that same cycle.
4. Miss on 0x8000_0420; assert inst_cancel during REFILL -> line installed, no data_ok, index_ok resumes in LOOKUP. Re-request 0x8000_0420 -> hit, no rd_req.
5. Conflict: 0x8000_0010 then 0x8000_0410 (same index, different tag) -> second request misses and refills; a later 0x8000_0010 misses again.
6. Assert rst low mid-REFILL -> rd_req=0, index_ok=0, data_ok=0 immediately. After release, the previously installed address misses (valid bits cleared).

Source files
------------

// File: rtl/icache_fetch_responder.sv
// Responder side of the IF fetch handshake: a two-stage direct-mapped instruction cache
// with 16-byte lines and a small FSM that refills missing lines over a burst read port.
module icache_fetch_responder #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 25 - INDEX_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inst_req,
    input  logic [31:0]  inst_vaddr,
    input  logic         inst_cancel,
    input  logic         inst_stage2_allowin,
    output logic         inst_index_ok,
    output logic         inst_data_ok,
    output logic [127:0] inst_rdata,
    output logic         rd_req,
    output logic [31:0]  rd_addr,
    input  logic         rd_rdy,
    input  logic         ret_valid,
    input  logic         ret_last,
    input  logic [31:0]  ret_data
);

    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {LOOKUP, MISS, REFILL} state_e;

    state_e       state_q, state_d;
    logic         s2_valid_q, s2_valid_d;
    logic [31:0]  s2_vaddr_q, s2_vaddr_d;
    logic         s2_canceled_q, s2_canceled_d;
    logic         rd_req_q, rd_req_d;
    logic [31:0]  rd_addr_q, rd_addr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [31:0]  buf_q [4];

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [127:0]     data_q [LINES];

    logic [INDEX_W-1:0] s2_idx;
    logic [TAG_W-1:0]   s2_tag;
    logic               hit;
    logic               in_lookup;
    logic               s2_leave;
    logic               refill_word;
    logic               refill_done;
    logic [127:0]       fill_line;
    logic               unused_vaddr_bits;

    assign s2_idx            = s2_vaddr_q[INDEX_W+3:4];
    assign s2_tag            = s2_vaddr_q[28:INDEX_W+4];
    assign unused_vaddr_bits = ^{s2_vaddr_q[31:29], s2_vaddr_q[3:0]};

    assign hit         = s2_valid_q && valid_q[s2_idx] && (tag_q[s2_idx] == s2_tag);
    assign in_lookup   = (state_q == LOOKUP);
    assign s2_leave    = s2_canceled_q || inst_cancel || (hit && inst_stage2_allowin);
    assign refill_word = (state_q == REFILL) && ret_valid;
    assign refill_done = refill_word && ret_last;

    // Handshake outputs are forced low while reset is held, independent of inputs.
    assign inst_index_ok = rst && in_lookup && inst_req && (!s2_valid_q || s2_leave);
    assign inst_data_ok  = rst && in_lookup && hit && !s2_canceled_q && !inst_cancel;
    assign inst_rdata    = inst_data_ok ? data_q[s2_idx] : '0;
    assign rd_req        = rd_req_q;
    assign rd_addr       = rd_addr_q;

    // The word arriving with ret_last is merged directly into the installed line.
    always_comb begin
        fill_line = '0;
        for (int w = 0; w < 4; w++) begin
            fill_line[32*w +: 32] = (cnt_q == 2'(w)) ? ret_data : buf_q[w];
        end
    end

    always_comb begin
        state_d       = state_q;
        s2_valid_d    = s2_valid_q;
        s2_vaddr_d    = s2_vaddr_q;
        s2_canceled_d = s2_canceled_q;
        rd_req_d      = rd_req_q;
        rd_addr_d     = rd_addr_q;
        cnt_d         = cnt_q;
        unique case (state_q)
            LOOKUP: begin
                if (inst_index_ok) begin
                    s2_valid_d    = 1'b1;
                    s2_vaddr_d    = inst_vaddr;
                    s2_canceled_d = inst_cancel;
                end else if (s2_valid_q && s2_leave) begin
                    s2_valid_d    = 1'b0;
                    s2_canceled_d = 1'b0;
                end else if (s2_valid_q && !hit) begin
                    rd_addr_d = {3'b000, s2_vaddr_q[28:4], 4'b0000};
                    rd_req_d  = 1'b1;
                    state_d   = MISS;
                end
            end
            MISS: begin
                if (inst_cancel) s2_canceled_d = 1'b1;
                if (rd_rdy) begin
                    rd_req_d = 1'b0;
                    cnt_d    = 2'd0;
                    state_d  = REFILL;
                end
            end
            REFILL: begin
                if (inst_cancel) s2_canceled_d = 1'b1;
                if (ret_valid) cnt_d = cnt_q + 2'd1;
                if (refill_done) state_d = LOOKUP;
            end
            default: state_d = LOOKUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= LOOKUP;
            s2_valid_q    <= 1'b0;
            s2_vaddr_q    <= '0;
            s2_canceled_q <= 1'b0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            cnt_q         <= 2'd0;
            valid_q       <= '0;
            for (int w = 0; w < 4; w++) buf_q[w] <= '0;
        end else begin
            state_q       <= state_d;
            s2_valid_q    <= s2_valid_d;
            s2_vaddr_q    <= s2_vaddr_d;
            s2_canceled_q <= s2_canceled_d;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= rd_addr_d;
            cnt_q         <= cnt_d;
            if (refill_word) buf_q[cnt_q] <= ret_data;
            if (refill_done) valid_q[s2_idx] <= 1'b1;
        end
    end

    // Tag and data arrays behave like RAM; only the valid bits need clearing on reset.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            data_q[s2_idx] <= fill_line;
            tag_q[s2_idx]  <= s2_tag;
        end
    end

endmodule
